// File: rtl/timing_generator_if.sv
// timing_generator_if
//   Bundle of every timing output produced by timing_generator and consumed
//   by the scratchpad, instruction decode and other timing-driven boards.
//   There is no valid/ready handshake: every signal is a register that is
//   valid in every sysclk cycle and changes only on the edge that enters a
//   new phase slot.
//
//   Signals:
//     clk1, clk2              non-overlapping two-phase clocks
//     a12 .. x32              clk2-aligned subcycle strobes
//     m11, m21                clk1-aligned subcycle strobes
//     m12_m22_clk1_m11_m12    data-in latch enable
//     sync_n                  active-low SYNC, low for all of X3
//     subcycle                current subcycle code, 0=A1 .. 7=X3
//   Modports: master (generator drives), slave (consumers observe).
interface timing_generator_if;
    logic       clk1;
    logic       clk2;
    logic       a12;
    logic       a22;
    logic       a32;
    logic       m12;
    logic       m22;
    logic       x12;
    logic       x22;
    logic       x32;
    logic       m11;
    logic       m21;
    logic       m12_m22_clk1_m11_m12;
    logic       sync_n;
    logic [2:0] subcycle;

    modport master (
        output clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32,
               m11, m21, m12_m22_clk1_m11_m12, sync_n, subcycle
    );

    modport slave (
        input  clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32,
               m11, m21, m12_m22_clk1_m11_m12, sync_n, subcycle
    );
endinterface

// File: rtl/timing_generator.sv
// timing_generator
//   Two-phase clock and machine-cycle sequencer for the 4004 core. Divides
//   sysclk into four phase slots of PHASE_LEN cycles each (slot 0 = clk1,
//   slot 2 = clk2, slots 1/3 = gaps) and steps through subcycles A1..X3.
//
//   Ports:
//     sysclk  in   the only clock
//     poc     in   power-on clear, synchronous, active-high
//     tim     timing_generator_if.master, all timing outputs (registered)
//   Parameter:
//     PHASE_LEN  sysclk cycles per phase slot, 1..255
module timing_generator #(
    parameter int PHASE_LEN = 17
) (
    input  logic                sysclk,
    input  logic                poc,
    timing_generator_if.master  tim
);

    typedef enum logic [2:0] {
        SC_A1 = 3'd0,
        SC_A2 = 3'd1,
        SC_A3 = 3'd2,
        SC_M1 = 3'd3,
        SC_M2 = 3'd4,
        SC_X1 = 3'd5,
        SC_X2 = 3'd6,
        SC_X3 = 3'd7
    } subcycle_t;

    localparam logic [7:0] PCNT_LAST = 8'(PHASE_LEN - 1);

    // Counter state; the subcycle register doubles as the visible state.
    logic [7:0] pcnt_q, pcnt_d;
    logic [1:0] slot_q, slot_d;
    subcycle_t  sc_q, sc_d;

    // Output registers. s2 bit S is the clk2-aligned strobe of subcycle S.
    logic [7:0] s2_q, s2_d;
    logic       clk1_q, clk1_d;
    logic       clk2_q, clk2_d;
    logic       m11_q, m11_d;
    logic       m21_q, m21_d;
    logic       en_q, en_d;
    logic       sync_n_q, sync_n_d;

    logic       pcnt_wrap;
    logic       enter_slot0;
    logic       enter_slot2;
    logic [2:0] sc_inc;

    always_ff @(posedge sysclk) begin
        if (poc) begin
            // Park in the last slot of X2 so release reaches X3.slot0
            // after exactly PHASE_LEN edges.
            pcnt_q   <= 8'd0;
            slot_q   <= 2'd3;
            sc_q     <= SC_X2;
            s2_q     <= 8'd0;
            clk1_q   <= 1'b0;
            clk2_q   <= 1'b0;
            m11_q    <= 1'b0;
            m21_q    <= 1'b0;
            en_q     <= 1'b0;
            sync_n_q <= 1'b1;
        end else begin
            pcnt_q   <= pcnt_d;
            slot_q   <= slot_d;
            sc_q     <= sc_d;
            s2_q     <= s2_d;
            clk1_q   <= clk1_d;
            clk2_q   <= clk2_d;
            m11_q    <= m11_d;
            m21_q    <= m21_d;
            en_q     <= en_d;
            sync_n_q <= sync_n_d;
        end
    end

    always_comb begin
        pcnt_d   = pcnt_q + 8'd1;
        slot_d   = slot_q;
        sc_d     = sc_q;
        s2_d     = s2_q;
        m11_d    = m11_q;
        m21_d    = m21_q;
        sync_n_d = sync_n_q;
        sc_inc   = sc_q + 3'd1;

        pcnt_wrap   = (pcnt_q == PCNT_LAST);
        enter_slot0 = pcnt_wrap && (slot_q == 2'd3);
        enter_slot2 = pcnt_wrap && (slot_q == 2'd1);

        if (pcnt_wrap) begin
            pcnt_d = 8'd0;
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
                sc_d = subcycle_t'(sc_inc);
            end
        end

        // Strobes are set/cleared only on slot entry events, never decoded
        // from position, so a strobe whose rise preceded reset release
        // stays low until its next real rise.
        if (enter_slot2) begin
            s2_d = 8'b0000_0001 << sc_d;
        end

        if (enter_slot0) begin
            m11_d    = (sc_d == SC_M1);
            m21_d    = (sc_d == SC_M2);
            sync_n_d = (sc_d != SC_X3);
        end

        clk1_d = (slot_d == 2'd0);
        clk2_d = (slot_d == 2'd2);

        // Built from next-state terms so the registered enable lines up
        // with the other outputs and cannot glitch.
        en_d = s2_d[3] | s2_d[4] | (clk1_d & ~(m11_d | s2_d[3]));
    end

    assign tim.clk1                 = clk1_q;
    assign tim.clk2                 = clk2_q;
    assign tim.a12                  = s2_q[0];
    assign tim.a22                  = s2_q[1];
    assign tim.a32                  = s2_q[2];
    assign tim.m12                  = s2_q[3];
    assign tim.m22                  = s2_q[4];
    assign tim.x12                  = s2_q[5];
    assign tim.x22                  = s2_q[6];
    assign tim.x32                  = s2_q[7];
    assign tim.m11                  = m11_q;
    assign tim.m21                  = m21_q;
    assign tim.m12_m22_clk1_m11_m12 = en_q;
    assign tim.sync_n               = sync_n_q;
    assign tim.subcycle             = sc_q;

endmodule

// File: tb/tb_timing_generator.sv
// tb_timing_generator
//   Drives one shared poc into three timing_generator instances
//   (PHASE_LEN = 2, 17, 1). For every edge the expected output vector of
//   each instance is pushed into its queue; a monitor pops and compares
//   after each edge. Directed spot checks and pulse-width measurements add
//   hand-computed constants.
module tb_timing_generator;

    localparam int W = 17;

    logic sysclk = 1'b0;
    logic poc    = 1'b1;

    always #5 sysclk = ~sysclk;

    timing_generator_if tif2 ();
    timing_generator_if tif17 ();
    timing_generator_if tif1 ();

    timing_generator #(.PHASE_LEN(2))  dut2  (.sysclk(sysclk), .poc(poc), .tim(tif2));
    timing_generator #(.PHASE_LEN(17)) dut17 (.sysclk(sysclk), .poc(poc), .tim(tif17));
    timing_generator #(.PHASE_LEN(1))  dut1  (.sysclk(sysclk), .poc(poc), .tim(tif1));

    // {clk1, clk2, a12..x32, m11, m21, en, sync_n, subcycle}
    logic [W-1:0] v2, v17, v1;
    assign v2  = {tif2.clk1, tif2.clk2, tif2.a12, tif2.a22, tif2.a32, tif2.m12,
                  tif2.m22, tif2.x12, tif2.x22, tif2.x32, tif2.m11, tif2.m21,
                  tif2.m12_m22_clk1_m11_m12, tif2.sync_n, tif2.subcycle};
    assign v17 = {tif17.clk1, tif17.clk2, tif17.a12, tif17.a22, tif17.a32, tif17.m12,
                  tif17.m22, tif17.x12, tif17.x22, tif17.x32, tif17.m11, tif17.m21,
                  tif17.m12_m22_clk1_m11_m12, tif17.sync_n, tif17.subcycle};
    assign v1  = {tif1.clk1, tif1.clk2, tif1.a12, tif1.a22, tif1.a32, tif1.m12,
                  tif1.m22, tif1.x12, tif1.x22, tif1.x32, tif1.m11, tif1.m21,
                  tif1.m12_m22_clk1_m11_m12, tif1.sync_n, tif1.subcycle};

    logic [W-1:0] exp_q2[$];
    logic [W-1:0] exp_q17[$];
    logic [W-1:0] exp_q1[$];

    int errors = 0;
    int checks = 0;
    int n      = 0;   // edges sampled with poc=0 since last poc=1 edge

    // ---------------- reference model ----------------
    // Position g in a machine cycle (sysclk units from A1.slot0). A pulse
    // that starts at 'start' and lasts 'width' is high only if the edge that
    // started it came after release (edge index >= 1).
    function automatic bit high(int pl, int nn, int g, int start, int width);
        int elapsed;
        elapsed = (g - start + 32 * pl) % (32 * pl);
        return (elapsed < width) && ((nn - elapsed) >= 1);
    endfunction

    function automatic logic [W-1:0] model(int pl, int nn, logic rst);
        int g, sc, slot;
        logic [7:0] s2;
        logic c1, c2, m11, m21, en, syn;
        logic [2:0] scv;
        if (rst) return {2'b00, 8'h00, 2'b00, 1'b0, 1'b1, 3'd6};
        g    = (27 * pl + nn) % (32 * pl);
        sc   = g / (4 * pl);
        slot = (g / pl) % 4;
        c1   = (slot == 0);
        c2   = (slot == 2);
        for (int s = 0; s < 8; s++) s2[s] = high(pl, nn, g, s * 4 * pl + 2 * pl, 4 * pl);
        m11  = high(pl, nn, g, 12 * pl, 4 * pl);
        m21  = high(pl, nn, g, 16 * pl, 4 * pl);
        syn  = !high(pl, nn, g, 28 * pl, 4 * pl);
        en   = s2[3] | s2[4] | (c1 & ~(m11 | s2[3]));
        scv  = 3'(sc);
        return {c1, c2, s2[0], s2[1], s2[2], s2[3], s2[4], s2[5], s2[6], s2[7],
                m11, m21, en, syn, scv};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic p);
        @(negedge sysclk);
        poc = p;
        if (p) n = 0;
        else   n = n + 1;
        exp_q2.push_back(model(2, n, p));
        exp_q17.push_back(model(17, n, p));
        exp_q1.push_back(model(1, n, p));
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic settle();
        @(posedge sysclk);
        #2;
    endtask

    // ---------------- scoreboard monitor + measurement ----------------
    int cyc = 0;
    bit measure = 1'b0;
    logic p_c1 = 1'b0, p_c2 = 1'b0, p_sn = 1'b1;
    int last_c2_rise = -1;
    int r1_q[$];
    int w2_q[$];
    int sf_q[$];

    always begin
        logic [W-1:0] e;
        @(posedge sysclk);
        #1;
        cyc++;
        if (exp_q2.size() > 0) begin
            e = exp_q2.pop_front();
            checks++;
            if (v2 !== e) begin
                errors++;
                $display("FAIL pl2_vec cyc=%0d got=%h exp=%h", cyc, v2, e);
            end
        end
        if (exp_q17.size() > 0) begin
            e = exp_q17.pop_front();
            checks++;
            if (v17 !== e) begin
                errors++;
                $display("FAIL pl17_vec cyc=%0d got=%h exp=%h", cyc, v17, e);
            end
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            checks++;
            if (v1 !== e) begin
                errors++;
                $display("FAIL pl1_vec cyc=%0d got=%h exp=%h", cyc, v1, e);
            end
        end
        if (tif2.clk1 && tif2.clk2) begin
            checks++;
            errors++;
            $display("FAIL pl2_overlap cyc=%0d got=1 exp=0", cyc);
        end
        if (measure) begin
            if (tif17.clk1 && !p_c1) r1_q.push_back(cyc);
            if (tif17.clk2 && !p_c2) last_c2_rise = cyc;
            if (!tif17.clk2 && p_c2 && last_c2_rise >= 0) w2_q.push_back(cyc - last_c2_rise);
            if (!tif17.sync_n && p_sn) sf_q.push_back(cyc);
        end
        p_c1 = tif17.clk1;
        p_c2 = tif17.clk2;
        p_sn = tif17.sync_n;
    end

    // ---------------- stimulus ----------------
    initial begin
        // Hold poc for 5 edges.
        for (int i = 0; i < 5; i++) step(1'b1);
        settle();
        chk("reset_vec_pl2", int'(v2), 32'h0000e);
        chk("reset_vec_pl17", int'(v17), 32'h0000e);

        // Release; run past 3 PHASE_LEN=2 machine cycles to M1.slot2.
        for (int i = 1; i <= 230; i++) begin
            step(1'b0);
            if (i == 2) begin
                settle();
                chk("rel_clk1", int'(tif2.clk1), 1);
                chk("rel_sync_n", int'(tif2.sync_n), 0);
                chk("rel_subcycle", int'(tif2.subcycle), 7);
            end else if (i == 10) begin
                settle();
                chk("a1_clk1", int'(tif2.clk1), 1);
                chk("a1_subcycle", int'(tif2.subcycle), 0);
                chk("a1_sync_n", int'(tif2.sync_n), 1);
                chk("a1_en", int'(tif2.m12_m22_clk1_m11_m12), 1);
            end else if (i == 14) begin
                settle();
                chk("a12_rise", int'(tif2.a12), 1);
                chk("a12_clk2", int'(tif2.clk2), 1);
            end else if (i == 22) begin
                settle();
                chk("a12_fall", int'(tif2.a12), 0);
                chk("a22_rise", int'(tif2.a22), 1);
            end else if (i == 34) begin
                settle();
                chk("m1_m11", int'(tif2.m11), 1);
                chk("m1_en", int'(tif2.m12_m22_clk1_m11_m12), 0);
                chk("m1_subcycle", int'(tif2.subcycle), 3);
            end else if (i == 230) begin
                settle();
                chk("pre_poc_subcycle", int'(tif2.subcycle), 3);
                chk("pre_poc_clk2", int'(tif2.clk2), 1);
            end
        end

        // One-edge poc in M1.slot2.
        step(1'b1);
        settle();
        chk("midrun_reset_pl2", int'(v2), 32'h0000e);
        chk("midrun_reset_pl1", int'(v1), 32'h0000e);

        // Long run for the default divider measurements.
        measure = 1'b1;
        for (int i = 1; i <= 1200; i++) step(1'b0);
        repeat (2) settle();

        if (r1_q.size() >= 3) begin
            chk("pl17_clk1_period_a", r1_q[1] - r1_q[0], 68);
            chk("pl17_clk1_period_b", r1_q[2] - r1_q[1], 68);
        end else begin
            chk("pl17_clk1_rises", r1_q.size(), 3);
        end
        if (w2_q.size() > 0) begin
            foreach (w2_q[k]) chk("pl17_clk2_width", w2_q[k], 17);
        end else begin
            chk("pl17_clk2_pulses", 0, 1);
        end
        if (sf_q.size() >= 2) begin
            chk("pl17_machine_cycle", sf_q[1] - sf_q[0], 544);
        end else begin
            chk("pl17_sync_falls", sf_q.size(), 2);
        end

        chk("q2_drained", exp_q2.size(), 0);
        chk("q17_drained", exp_q17.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
